pipelined_alu: RTL

Parametrised, handshaked successor to the processor's combinational ALU. It executes a widened RV32-style operation set on WIDTH-bit operands and registers the result and zero flag. When the multiply/divide feature is compiled in, it also runs iterative shift-add multiply and restoring unsigned divide/remainder over WIDTH cycles. It sits between the decode/register-read stage and writeback, and a valid/ready handshake lets the multi-cycle operations stall the datapath.

---
 rtl/pipelined_alu.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_alu.sv
// pipelined_alu: handshaked ALU with registered result and zero flag.
// Single-cycle ops (ADD..SRA) complete one cycle after acceptance.
// Optional macro PIPELINED_ALU_MULDIV_EN adds iterative MUL / DIVU / REMU
// (shift-add multiply, restoring unsigned divide). Without the macro those
// opcodes behave as undefined (result 0, zero_flag 1, one-cycle latency).
module pipelined_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic             accept;
  logic             start_iter;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;

  // A new op is taken when idle, or when the pending result leaves this cycle.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign shamt     = b[SHAMT_W-1:0];
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero_flag = zero_q;

  // Single-cycle result computed straight from the input operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_MUL, OP_DIVU, OP_REMU: alu_res = '0; // iterative path or undefined
      default: alu_res = '0;
    endcase
  end

`ifdef PIPELINED_ALU_MULDIV_EN
  // Counter runs 0..WIDTH-1 over the datapath steps; the extra value WIDTH is
  // the cycle that transfers the finished value into the result register.
  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;     // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] y_q, y_d;     // multiplier, or divisor
  logic [WIDTH-1:0] acc_q, acc_d; // product, or partial remainder
  logic [WIDTH:0]   rem_sh;

  assign start_iter = accept && ((alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU));
  assign busy       = (state_q == S_BUSY);
  assign iter_done  = (state_q == S_BUSY) && (cnt_q == CNT_LAST);
  assign iter_res   = (op_q == OP_DIVU) ? x_q : acc_q;

  // One shift-add or restoring-subtract step per BUSY cycle.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    rem_sh = '0;
    if (start_iter) begin
      op_d  = alu_op;
      x_d   = a;
      y_d   = b;
      acc_d = '0;
      cnt_d = '0;
    end else if ((state_q == S_BUSY) && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (op_q == OP_MUL) begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end else begin
        // Divisor 0 always "fits": quotient becomes all ones, remainder a.
        rem_sh = {acc_q, x_q[WIDTH-1]};
        x_d    = x_q << 1;
        if (rem_sh >= {1'b0, y_q}) begin
          rem_sh = rem_sh - {1'b0, y_q};
          x_d[0] = 1'b1;
        end
        acc_d = rem_sh[WIDTH-1:0];
      end
    end
  end

  // Iterative datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      op_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
    end
  end
`else
  assign start_iter = 1'b0;
  assign busy       = 1'b0;
  assign iter_done  = 1'b0;
  assign iter_res   = '0;
`endif

  // Control FSM: IDLE accepts, BUSY iterates, DONE holds the result until taken.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
        if (start_iter) begin
          out_valid_d = 1'b0;
          state_d     = S_BUSY;
        end else if (accept) begin
          result_d    = alu_res;
          zero_d      = (alu_res == '0);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_BUSY: begin
        if (iter_done) begin
          result_d    = iter_res;
          zero_d      = (iter_res == '0);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
